// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared widths, control encodings and condition-flag type for the ALU
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // Condition codes consumed by cmov/jump evaluation in execute.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(input logic is_zero,
                                              input logic msb,
                                              input logic ovf);
        alu_flags_t f;
        f.zf = is_zero;
        f.sf = msb;
        f.of = ovf;
        return f;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// alu_addsub : combinational two's-complement adder/subtractor with signed overflow
// Rev 1.0
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_carry_in;

    // Subtraction is a + ~b + 1, so one adder serves both operations.
    assign w_b_eff    = sub ? ~b : b;
    assign w_carry_in = {{(WIDTH-1){1'b0}}, sub};
    assign sum        = a + w_b_eff + w_carry_in;

    // Overflow when the effective addends agree in sign but the sum does not.
    assign overflow = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : alu_addsub
`default_nettype wire

// File: rtl/alu_64.sv
`default_nettype none
// ============================================================================
// alu_64 : registered 64-bit Y86-64 ALU (add/sub/and/xor) with ZF/SF/OF flags
// Rev 1.0
// ============================================================================
module alu_64
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic             overflow,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sum;
    logic             w_addsub_ovf;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_result;
    logic             w_result_ovf;
    alu_flags_t       w_flags;

    logic [WIDTH-1:0] r_ans;
    logic             r_overflow;
    alu_flags_t       r_flags;
    logic             r_out_valid;

    assign w_is_sub = (control == ALU_SUB);

    alu_addsub #(
        .WIDTH    (WIDTH)
    ) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (w_is_sub),
        .sum      (w_sum),
        .overflow (w_addsub_ovf)
    );

    always_comb begin
        w_result     = w_sum;
        w_result_ovf = 1'b0;
        case (control)
            ALU_ADD,
            ALU_SUB: begin
                w_result     = w_sum;
                w_result_ovf = w_addsub_ovf;
            end
            ALU_AND: w_result = a & b;
            ALU_XOR: w_result = a ^ b;
            default: w_result = w_sum;
        endcase
    end

    // Flags come from the value about to be registered, not the held one.
    assign w_flags = make_flags(w_result == '0, w_result[WIDTH-1], w_result_ovf);

    // Result and flags hold on idle cycles so later conditionals still see them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ans       <= '0;
            r_overflow  <= 1'b0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_ans      <= w_result;
                r_overflow <= w_result_ovf;
                r_flags    <= w_flags;
            end
        end
    end

    assign ans       = r_ans;
    assign overflow  = r_overflow;
    assign zf        = r_flags.zf;
    assign sf        = r_flags.sf;
    assign of        = r_flags.of;
    assign out_valid = r_out_valid;

endmodule : alu_64
`default_nettype wire

// File: tb/tb_alu_64.sv
`default_nettype none
// ============================================================================
// tb_alu_64 : randomized scoreboard bench for alu_64 against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_alu_64;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] ans;
        logic         ovf;
        logic         zf;
        logic         sf;
        logic         of;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [1:0]   control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ans;
    logic         overflow;
    logic         zf;
    logic         sf;
    logic         of;
    logic         out_valid;

    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t last_exp;

    alu_64 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .control   (control),
        .a         (a),
        .b         (b),
        .ans       (ans),
        .overflow  (overflow),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed arithmetic in 66 bits; overflow means the exact
    // result does not fit the 64-bit signed range.
    function automatic exp_t model(input logic [1:0] c, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        logic signed [W+1:0] sx, sy, full, trunc;
        sx = $signed(x);
        sy = $signed(y);
        e.ovf = 1'b0;
        case (c)
            2'd0: full = sx + sy;
            2'd1: full = sx - sy;
            2'd2: full = $signed({2'b00, x & y});
            default: full = $signed({2'b00, x ^ y});
        endcase
        e.ans = full[W-1:0];
        if (c < 2'd2) begin
            trunc = $signed(e.ans);
            e.ovf = (full != trunc);
        end
        e.zf = (e.ans == '0);
        e.sf = e.ans[W-1];
        e.of = e.ovf;
        return e;
    endfunction

    function automatic exp_t outputs_now();
        exp_t g;
        g.ans = ans;
        g.ovf = overflow;
        g.zf  = zf;
        g.sf  = sf;
        g.of  = of;
        return g;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got ans=%h ovf=%b zf=%b sf=%b of=%b, want ans=%h ovf=%b zf=%b sf=%b of=%b",
                     name, got.ans, got.ovf, got.zf, got.sf, got.of,
                     want.ans, want.ovf, want.zf, want.sf, want.of);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        control  = c;
        a        = x;
        b        = y;
        exp_q.push_back(model(c, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: pops on each out_valid; on idle cycles the outputs must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp = '0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, want 0 (no op pending)");
                end else begin
                    last_exp = exp_q.pop_front();
                    check("result", outputs_now(), last_exp);
                end
            end else begin
                check("hold", outputs_now(), last_exp);
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        last_exp = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        control  = 2'b00;
        a        = '0;
        b        = '0;
        #2;
        check("reset_outputs", outputs_now(), '0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        issue(2'b00, 64'd5, 64'd7);
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(2'b01, 64'd3, 64'd3);
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd1);
        issue(2'b01, 64'd2, 64'd5);
        idle(1);
        issue(2'b10, 64'hF0F0, 64'h0FF0);
        issue(2'b11, 64'hF0F0, 64'h0FF0);
        issue(2'b11, '1, '1);
        issue(2'b00, '1, 64'd1);
        idle(2);
        issue(2'b00, 64'd100, 64'd23);
        issue(2'b01, 64'd100, 64'd23);
        issue(2'b11, 64'h1234, 64'h00FF);
        idle(3);

        // Asynchronous reset between edges discards the in-flight result.
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        check_bit("valid_before_reset", out_valid, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_outputs", outputs_now(), '0);
        check_bit("async_reset_out_valid", out_valid, 1'b0);
        in_valid = 1'b1;
        control  = 2'b00;
        a        = 64'd9;
        b        = 64'd9;
        @(posedge clk);
        #1;
        check("reset_held_outputs", outputs_now(), '0);
        check_bit("reset_held_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 2));
            else
                issue(2'($urandom_range(0, 3)), pick(), pick());
        end
        idle(1);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d results pending, want 0", exp_q.size());
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_64
`default_nettype wire

// File: doc/alu_64.md
Name: alu_64

Overview:
- 64-bit two's-complement ALU for the Y86-64 execute stage.
- Performs add, subtract, bitwise AND and bitwise XOR on operands a and b, selected by a 2-bit control code.
- Result, signed-overflow indication and condition flags (ZF/SF/OF) are registered, giving one cycle of latency. The execute stage consumes them for valE and for cmov/jump condition evaluation.

Parameters:
- WIDTH, 64, operand/result width in bits; all arithmetic is two's-complement at this width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands/control valid this cycle; captured on the rising clk edge
- control  input  2  operation: 00 add, 01 sub, 10 and, 11 xor
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- ans  output  WIDTH  registered result
- overflow  output  1  registered signed-overflow flag for ans
- zf  output  1  registered zero flag (ans == 0)
- sf  output  1  registered sign flag (ans[WIDTH-1])
- of  output  1  registered overflow flag, equal to overflow
- out_valid  output  1  high for exactly one cycle, one cycle after an accepted in_valid

Behaviour:
- rst high (asynchronous): ans=0, overflow=0, zf=0, sf=0, of=0, out_valid=0. Outputs hold these values while rst is asserted. Release is sampled at the next rising clk.
- Latency: 1 cycle. Inputs sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1.
- Throughput: one operation per cycle. Back-to-back in_valid pulses produce back-to-back out_valid pulses; no stall or backpressure.
- in_valid=0 at an edge: out_valid goes to 0. ans, overflow and the flags hold their previous values, so flags persist for later conditional instructions.
- Operations, all results truncated modulo 2^WIDTH:
  - 00: ans = a + b
  - 01: ans = a - b (a minus b; the caller orders operands)
  - 10: ans = a & b
  - 11: ans = a ^ b
- Overflow:
  - add: set when a and b have the same sign and ans sign differs from a.
  - sub: set when a and b have different signs and ans sign differs from a.
  - and/xor: always 0.
- Flags are computed from the result being registered, not from the previous result. zf = (ans==0), sf = ans MSB, of = overflow. All flags update on every accepted operation, including logic operations.
- No carry output. Unsigned wrap (e.g. all-ones + 1) is not overflow unless the signed rule triggers.
- rst asserted mid-operation: the in-flight result is discarded and out_valid is forced to 0 immediately.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default
  - control encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11
  - a packed flags struct {zf, sf, of}, reused by the condition-code logic in execute.
- One sub-module, alu_addsub: combinational add/subtract (b inverted with carry-in for sub) producing sum and signed overflow.
- Logic operations, the result mux and the output registers live in alu_64.

Test Plan:
- Reset: assert rst asynchronously between edges with prior non-zero outputs -> ans=0, overflow=zf=sf=of=0 and out_valid=0 immediately; values hold until release.
- Add: a=5, b=7, control=00, in_valid=1 -> next cycle ans=12, zf=0, sf=0, of=0, out_valid=1. Then a=0x7FFFFFFFFFFFFFFF, b=1 -> ans=0x8000000000000000, overflow=of=1, sf=1.
- Sub: a=3, b=3, control=01 -> ans=0, zf=1, sf=0, of=0. Then a=0x8000000000000000, b=1 -> ans=0x7FFFFFFFFFFFFFFF, of=1, sf=0. Then a=2, b=5 -> ans=-3 (0xFFFFFFFFFFFFFFFD), sf=1, of=0.
- Logic: a=0xF0F0, b=0x0FF0, control=10 -> ans=0x00F0, of=0. Same operands with control=11 -> ans=0xFF00. a=b=0xFFFFFFFFFFFFFFFF with control=11 -> ans=0, zf=1.
- Pipelining/hold: three consecutive valid ops (add, sub, xor) -> three consecutive out_valid cycles with matching results. Next cycle in_valid=0 -> out_valid=0, ans and flags unchanged.
- Wrap without overflow: a=0xFFFFFFFFFFFFFFFF, b=1, add -> ans=0, zf=1, of=0.
